// File: rtl/window5x5_s8.sv
// Sliding KxK window generator over a raster pixel stream (LeNet-5 conv1 input side).
// Latency: out_valid exactly 1 clk after the in_valid beat that completes a window.
// Backpressure: none; accepts one pixel per in_valid beat, back-to-back every clk.
//
// Ports:
//   clk, arst_n                 clock, asynchronous active-low reset
//   in_valid, in_pixel          pixel beat in raster order (signed DW bits, passed through as raw bits)
//   in_line_last, in_frame_last framing markers, qualified by in_valid
//   out_valid                   one-cycle pulse per emitted window
//   out_win                     KxK taps, tap (r,c) at [(r*K+c)*DW +: DW], r=0 oldest line, c=0 leftmost
//   out_row, out_col            output window position
//   out_line_last               last window of an output row
//   out_frame_last              last window of the frame
//   err_sync                    sticky framing error, cleared only by reset
module window5x5_s8 #(
    parameter int W  = 32,
    parameter int H  = 32,
    parameter int K  = 5,
    parameter int DW = 8
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  in_valid,
    input  logic [DW-1:0]         in_pixel,
    input  logic                  in_line_last,
    input  logic                  in_frame_last,
    output logic                  out_valid,
    output logic [K*K*DW-1:0]     out_win,
    output logic                  out_line_last,
    output logic                  out_frame_last,
    output logic [$clog2(H)-1:0]  out_row,
    output logic [$clog2(W)-1:0]  out_col,
    output logic                  err_sync
);

    localparam int CW   = $clog2(W);
    localparam int RW   = $clog2(H);
    localparam int TAPS = K * K;

    localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
    localparam logic [CW-1:0] COL_WIN0 = CW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);
    localparam logic [RW-1:0] ROW_WIN0 = RW'(K - 1);

    // Position of the pixel currently presented on in_pixel
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CW-1:0] col_d;
    logic [RW-1:0] row_d;
    logic          err_d;

    // Line buffers: lbuf[j] holds line row-1-j, indexed by column.
    // No reset: a stale entry can never reach an emitted window, since emission
    // needs K-1 freshly written lines above the current one.
    logic [DW-1:0] lbuf  [K-1][W];
    logic [DW-1:0] lb_rd [K-1];

    logic [TAPS*DW-1:0] win_q;
    logic [TAPS*DW-1:0] win_d;

    logic at_col_last;
    logic at_row_last;
    logic emit;

    assign at_col_last = (col == COL_LAST);
    assign at_row_last = (row == ROW_LAST);
    assign emit        = in_valid && (row >= ROW_WIN0) && (col >= COL_WIN0);

    // Column read of every line buffer at the current position
    always_comb begin
        for (int j = 0; j < K - 1; j++) begin
            lb_rd[j] = lbuf[j][col];
        end
    end

    // Shift chain down the lines: newest pixel into buf0, each buffer takes
    // the value the buffer above held at this column.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lbuf[0][col] <= in_pixel;
            for (int j = 1; j < K - 1; j++) begin
                lbuf[j][col] <= lb_rd[j-1];
            end
        end
    end

    // Window: shift every row one column left, load the new right column
    // with the oldest line at the top and the live pixel at the bottom.
    always_comb begin
        win_d = win_q;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                win_d[(r*K+c)*DW +: DW] = win_q[(r*K+c+1)*DW +: DW];
            end
        end
        for (int r = 0; r < K - 1; r++) begin
            win_d[(r*K+K-1)*DW +: DW] = lb_rd[K-2-r];
        end
        win_d[((K-1)*K+K-1)*DW +: DW] = in_pixel;
    end

    // Position tracking with framing-error detection. A missing marker is
    // repaired by wrapping on the geometry so the stream resynchronises.
    always_comb begin
        col_d = col;
        row_d = row;
        err_d = err_sync;
        if (in_valid) begin
            if (in_frame_last) begin
                col_d = '0;
                row_d = '0;
                if (!(at_row_last && at_col_last)) begin
                    err_d = 1'b1;
                end
            end else if (in_line_last) begin
                col_d = '0;
                row_d = at_row_last ? '0 : row + 1'b1;
                if (!at_col_last) begin
                    err_d = 1'b1;
                end
            end else if (at_col_last) begin
                col_d = '0;
                row_d = at_row_last ? '0 : row + 1'b1;
                err_d = 1'b1;
            end else begin
                col_d = col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            col      <= '0;
            row      <= '0;
            err_sync <= 1'b0;
            win_q    <= '0;
        end else begin
            col      <= col_d;
            row      <= row_d;
            err_sync <= err_d;
            if (in_valid) begin
                win_q <= win_d;
            end
        end
    end

    // Output qualifiers registered alongside the window update so they line
    // up with the window contents one cycle after the completing beat.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            out_valid      <= 1'b0;
            out_row        <= '0;
            out_col        <= '0;
            out_line_last  <= 1'b0;
            out_frame_last <= 1'b0;
        end else begin
            out_valid <= emit;
            if (emit) begin
                out_row        <= row - ROW_WIN0;
                out_col        <= col - COL_WIN0;
                out_line_last  <= at_col_last;
                out_frame_last <= at_row_last && at_col_last;
            end
        end
    end

    assign out_win = win_q;

endmodule

// File: tb/tb_window5x5_s8.sv
module tb_window5x5_s8;

    localparam int W  = 32;
    localparam int H  = 32;
    localparam int K  = 5;
    localparam int DW = 8;
    localparam int WB = K * K * DW;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_pixel = '0;
    logic          in_line_last = 1'b0;
    logic          in_frame_last = 1'b0;
    logic          out_valid;
    logic [WB-1:0] out_win;
    logic          out_line_last;
    logic          out_frame_last;
    logic [4:0]    out_row;
    logic [4:0]    out_col;
    logic          err_sync;

    window5x5_s8 #(.W(W), .H(H), .K(K), .DW(DW)) dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .in_valid       (in_valid),
        .in_pixel       (in_pixel),
        .in_line_last   (in_line_last),
        .in_frame_last  (in_frame_last),
        .out_valid      (out_valid),
        .out_win        (out_win),
        .out_line_last  (out_line_last),
        .out_frame_last (out_frame_last),
        .out_row        (out_row),
        .out_col        (out_col),
        .err_sync       (err_sync)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [WB-1:0] act, input logic [WB-1:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    function automatic logic [DW-1:0] tap(input logic [WB-1:0] w, input int r, input int c);
        return w[(r*K+c)*DW +: DW];
    endfunction

    // ---------------- reference model ----------------
    // Each column keeps the last K values written to it (index K-1 newest);
    // the window is the last K beats' column snapshots.
    typedef struct {
        logic [WB-1:0] win;
        logic [4:0]    row;
        logic [4:0]    col;
        logic          ll;
        logic          fl;
        int            cyc;
        int            tag;
    } exp_t;

    exp_t          sbq[$];
    int            mrow = 0;
    int            mcol = 0;
    bit            merr = 1'b0;
    logic [DW-1:0] hist [W][K];
    logic [DW-1:0] snap [K][K];
    int            cur_tag = 0;

    task automatic model_reset();
        mrow = 0;
        mcol = 0;
        merr = 1'b0;
        for (int c = 0; c < K; c++)
            for (int r = 0; r < K; r++) snap[c][r] = '0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [DW-1:0] pix, input bit ll, input bit fl, input bit gaps);
        exp_t e;
        if (gaps) repeat ($urandom_range(1, 0)) idle();
        in_valid      = 1'b1;
        in_pixel      = pix;
        in_line_last  = ll;
        in_frame_last = fl;
        for (int r = 0; r < K - 1; r++) hist[mcol][r] = hist[mcol][r+1];
        hist[mcol][K-1] = pix;
        for (int c = 0; c < K - 1; c++)
            for (int r = 0; r < K; r++) snap[c][r] = snap[c+1][r];
        for (int r = 0; r < K; r++) snap[K-1][r] = hist[mcol][r];
        if (mrow >= K - 1 && mcol >= K - 1) begin
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++) e.win[(r*K+c)*DW +: DW] = snap[c][r];
            e.row = 5'(mrow - (K - 1));
            e.col = 5'(mcol - (K - 1));
            e.ll  = (mcol == W - 1);
            e.fl  = (mrow == H - 1) && (mcol == W - 1);
            e.cyc = cyc;
            e.tag = cur_tag;
            sbq.push_back(e);
        end
        if (fl) begin
            if (!(mrow == H - 1 && mcol == W - 1)) merr = 1'b1;
            mrow = 0;
            mcol = 0;
        end else if (ll) begin
            if (mcol != W - 1) merr = 1'b1;
            mcol = 0;
            mrow = (mrow + 1) % H;
        end else if (mcol == W - 1) begin
            merr = 1'b1;
            mcol = 0;
            mrow = (mrow + 1) % H;
        end else begin
            mcol = mcol + 1;
        end
        @(posedge clk);
        #1;
        in_valid      = 1'b0;
        in_line_last  = 1'b0;
        in_frame_last = 1'b0;
    endtask

    // kind 0: ramp r+c; 1: constant 100; 2: ramp with -128 at (0,0), 127 at (4,4);
    // 3: ramp with an early line_last at row 6, col 10. stop_after < 0 runs the full frame.
    task automatic frame(input int kind, input bit gaps, input int stop_after);
        int n;
        int last_c;
        logic [DW-1:0] p;
        n = 0;
        cur_tag = kind;
        for (int r = 0; r < H; r++) begin
            last_c = (kind == 3 && r == 6) ? 10 : W - 1;
            for (int c = 0; c <= last_c; c++) begin
                if (stop_after >= 0 && n >= stop_after) return;
                p = DW'(r + c);
                if (kind == 1) p = 8'd100;
                if (kind == 2 && r == 0 && c == 0) p = 8'h80;
                if (kind == 2 && r == 4 && c == 4) p = 8'h7F;
                drive(p, c == last_c, (r == H - 1) && (c == W - 1), gaps);
                if (kind == 3 && r == 6 && c == 10) chk("err_after_early_ll", err_sync, merr);
                n++;
            end
        end
    endtask

    // ---------------- monitor ----------------
    exp_t          me;
    int            win_cnt = 0;
    int            ll_cnt = 0;
    int            fl_cnt = 0;
    int            const_cnt = 0;
    int            const_bad = 0;
    logic [WB-1:0] first_win;
    logic [WB-1:0] last_win;

    always @(negedge clk) begin
        if (arst_n && out_valid) begin
            if (sbq.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_window: got row %0d col %0d, expected no window", out_row, out_col);
            end else begin
                me = sbq.pop_front();
                chk("window_taps", out_win, me.win);
                chk("window_pos_flags", {out_row, out_col, out_line_last, out_frame_last},
                    {me.row, me.col, me.ll, me.fl});
                chk("window_latency", WB'(cyc), WB'(me.cyc + 1));
                if (win_cnt == 0) first_win = out_win;
                last_win = out_win;
                win_cnt++;
                if (out_line_last) ll_cnt++;
                if (out_frame_last) fl_cnt++;
                if (me.tag == 1) begin
                    const_cnt++;
                    for (int t = 0; t < K * K; t++)
                        if (out_win[t*DW +: DW] != 8'd100) begin
                            const_bad++;
                            break;
                        end
                end
            end
        end
    end

    task automatic clear_counts();
        win_cnt = 0;
        ll_cnt = 0;
        fl_cnt = 0;
    endtask

    task automatic check_counts(input string tag_s, input int wins, input int lls, input int fls);
        chk({tag_s, "_windows"}, WB'(win_cnt), WB'(wins));
        chk({tag_s, "_line_last"}, WB'(ll_cnt), WB'(lls));
        chk({tag_s, "_frame_last"}, WB'(fl_cnt), WB'(fls));
        clear_counts();
    endtask

    initial begin
        model_reset();
        for (int c = 0; c < W; c++)
            for (int r = 0; r < K; r++) hist[c][r] = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid_flags", {out_valid, out_line_last, out_frame_last, err_sync}, 4'b0000);
        chk("reset_win", out_win, '0);
        chk("reset_pos", {out_row, out_col}, 10'd0);
        arst_n = 1'b1;
        idle();

        // contiguous ramp frame
        frame(0, 1'b0, -1);
        repeat (3) idle();
        chk("ramp_first_tap00", tap(first_win, 0, 0), 8'd0);
        chk("ramp_first_tap44", tap(first_win, 4, 4), 8'd8);
        chk("ramp_last_tap44", tap(last_win, 4, 4), 8'd62);
        chk("ramp_err", err_sync, 1'b0);
        check_counts("ramp", 784, 28, 1);

        // same frame with random input gaps
        frame(0, 1'b1, -1);
        repeat (3) idle();
        chk("gap_first_tap44", tap(first_win, 4, 4), 8'd8);
        chk("gap_last_tap44", tap(last_win, 4, 4), 8'd62);
        check_counts("gap", 784, 28, 1);

        // back-to-back ramp then constant frame
        const_cnt = 0;
        const_bad = 0;
        frame(0, 1'b0, -1);
        frame(1, 1'b0, -1);
        repeat (3) idle();
        check_counts("b2b", 1568, 56, 2);
        chk("const_windows", WB'(const_cnt), WB'(784));
        chk("const_leak", WB'(const_bad), WB'(0));

        // signed extremes
        frame(2, 1'b0, -1);
        repeat (3) idle();
        chk("ext_tap00", tap(first_win, 0, 0), 8'h80);
        chk("ext_tap44", tap(first_win, 4, 4), 8'h7F);
        check_counts("ext", 784, 28, 1);

        // early line_last at row 6 col 10; row 6 loses 21 windows and its line_last
        frame(3, 1'b0, -1);
        repeat (3) idle();
        chk("err_frame_sticky", err_sync, merr);
        check_counts("errf", 763, 27, 1);

        frame(0, 1'b0, -1);
        repeat (3) idle();
        chk("err_after_clean", err_sync, 1'b1);
        check_counts("post_err", 784, 28, 1);

        // reset mid-frame at row 15
        frame(0, 1'b1, 15 * W + 10);
        repeat (3) idle();
        arst_n = 1'b0;
        #2;
        chk("midrst_valid_flags", {out_valid, out_line_last, out_frame_last, err_sync}, 4'b0000);
        chk("midrst_win", out_win, '0);
        chk("midrst_pos", {out_row, out_col}, 10'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
        idle();
        clear_counts();
        frame(0, 1'b0, -1);
        repeat (3) idle();
        chk("after_rst_err", err_sync, 1'b0);
        chk("after_rst_last_tap44", tap(last_win, 4, 4), 8'd62);
        check_counts("after_rst", 784, 28, 1);

        chk("sb_drained", WB'(sbq.size()), WB'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/window5x5_s8.md
# window5x5_s8

Sliding 5x5 window generator for LeNet-5 conv1. Consumes the signed 8-bit 32x32 padded-frame stream that leaves the quantize stage (maxpool 20x20 → zero-pad rows → quantize s8). For every input pixel that completes a full window, it emits one 25-tap window, giving a 28x28 window stream per frame to the conv1 MAC array. No backpressure: it keeps up with the producer, one pixel per `in_valid` beat.

## Interface
- `W`, 32, frame width in pixels.
- `H`, 32, frame height in lines.
- `K`, 5, window size (KxK).
- `DW`, 8, pixel width; signed two's complement.

- `clk`  in  1  single clock for all logic.
- `arst_n`  in  1  async active-low reset.
- `in_valid`  in  1  input pixel beat qualifier.
- `in_pixel`  in  DW  signed pixel, raster order.
- `in_line_last`  in  1  marks last pixel of a line; qualified by `in_valid`.
- `in_frame_last`  in  1  marks last pixel of a frame; qualified by `in_valid`.
- `out_valid`  out  1  one-cycle pulse per window.
- `out_win`  out  K*K*DW  window; tap (r,c) at bits `[(r*K+c)*DW +: DW]`.
  - r=0 is the oldest (top) line; c=0 is the leftmost column.
- `out_line_last`  out  1  last window of an output row (out col = W-K).
- `out_frame_last`  out  1  last window of the frame (row H-K, col W-K).
- `out_row`  out  5  output row index, 0..H-K.
- `out_col`  out  5  output column index, 0..W-K.
- `err_sync`  out  1  sticky framing-error flag; cleared only by reset.

## Operation
- Position counters `col` (0..W-1) and `row` (0..H-1) advance only on `in_valid`. They index the current input pixel.
- Line buffers: K-1 buffers of W x DW, addressed by `col`.
  - Buffer j holds line row-1-j.
  - On each beat, read all K-1 at `col`, then write the shift chain: buf0 ← `in_pixel`, buf(j) ← old buf(j-1).
- Window register: KxK x DW.
  - On each beat, every row shifts left by one column.
  - Column K-1 loads {buf3, buf2, buf1, buf0, `in_pixel`} into rows 0..4.
- Emit condition, evaluated on the beat: `row >= K-1` and `col >= K-1`.
  - On emit, the next cycle drives `out_valid`=1, the updated window, `out_row`=row-(K-1), `out_col`=col-(K-1), and the line/frame flags.
- Counter update per beat:
  - `in_frame_last`: col←0, row←0. If (row,col) ≠ (H-1,W-1), set `err_sync`.
  - Else if `in_line_last`: col←0, row←row+1. If col ≠ W-1, set `err_sync`.
  - Else if col=W-1: col←0, row←row+1, and set `err_sync` (missing line_last). If row=H-1, row←0 instead (missing frame_last, also error).
  - Else: col←col+1.
- Line buffers are not cleared between frames. Stale data never reaches an emitted window, because emission requires K-1 fresh lines and K fresh columns.

## Timing
- Reset values: all outputs 0, counters 0, window 0, `err_sync` 0. Line-buffer contents are don't-care.
- Latency: exactly 1 clk from the completing `in_valid` beat to `out_valid`.
- `out_valid` follows input gaps beat-for-beat. Outputs are held between pulses but are meaningful only while `out_valid`=1.
- Line buffers: synchronous-read RAMs or registers. Back-to-back beats every clk must be sustained.
- Throughput per frame: (H-K+1)*(W-K+1) = 784 windows, 28 `out_line_last`, 1 `out_frame_last`.
- Frame boundary: the first beat of frame N+1 may immediately follow `in_frame_last` of frame N with no bubble.
- Async reset mid-frame: all state returns to reset values immediately. The next input beat is treated as pixel (0,0).

## Test plan
- Single frame, contiguous, pixel(r,c)=r+c:
  - First `out_valid` occurs 1 clk after input (4,4), with taps (0,0)=0 and (4,4)=8.
  - Last window is (27,27), with tap(4,4)=62 and `out_frame_last`=1.
  - Totals: 784 windows, 28 line_last pulses, `err_sync`=0.
- Same frame with ~50% random `in_valid` gaps → the window sequence and values are identical to the contiguous case; each window arrives 1 clk after its completing beat.
- Two back-to-back frames, frame 1 = ramp, frame 2 = constant 100 → every frame-2 window has all 25 taps = 100 (no frame-1 leakage); 784 windows each.
- `in_line_last` asserted early at row 6, col 10 → `err_sync`=1 (sticky); col→0, row→7 on the next beat. Flag still set after the following clean frame.
- `arst_n` pulsed low at row 15 mid-frame, then a clean ramp frame → outputs 0 during reset; the clean frame yields 784 correct windows with `err_sync`=0.
- Input values -128 and 127 at (0,0) and (4,4) → tap(0,0)=0x80 and tap(4,4)=0x7F with no sign corruption in `out_win`.
